// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined nibble-product multiplier with per-beat exact/approximate mode.
// Optional error statistics are enabled by defining AMP_ERR_STAT_EN.
module approx_mult_pipe #(
    parameter int WIDTH     = 8,
    parameter int TRUNC_NIB = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_approx
`ifdef AMP_ERR_STAT_EN
    ,
    input  logic               err_clr,
    output logic [15:0]        err_cnt,
    output logic [31:0]        err_sum
`endif
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned TN = TRUNC_NIB;

    logic adv;

    logic             s1_valid;
    logic             s1_mode;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_valid;
    logic             s2_mode;
    logic [7:0]       s2_prod  [N*N];
    logic [7:0]       nib_prod [N*N];
    logic [PW-1:0]    sum;

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_mode  <= in_approx;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end
    end

    always_comb begin
        nib_prod = '{default: '0};
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (s1_mode && ((i + j) < TN))
                    nib_prod[i*N+j] = '0;
                else
                    nib_prod[i*N+j] = {4'b0, s1_a[4*i +: 4]} * {4'b0, s1_b[4*j +: 4]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_prod  <= '{default: '0};
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_prod  <= nib_prod;
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                sum = sum + (PW'(s2_prod[i*N+j]) << (4 * (i + j)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_p      <= '0;
            out_approx <= 1'b0;
        end else if (adv) begin
            out_valid  <= s2_valid;
            out_p      <= sum;
            out_approx <= s2_mode;
        end
    end

`ifdef AMP_ERR_STAT_EN
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;
    logic [PW-1:0]    s3_exact;
    logic [PW-1:0]    diff;
    logic [64:0]      sum_ext;
    logic             err_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_a     <= '0;
            s2_b     <= '0;
            s3_exact <= '0;
        end else if (adv) begin
            s2_a     <= s1_a;
            s2_b     <= s1_b;
            s3_exact <= PW'(s2_a) * PW'(s2_b);
        end
    end

    assign diff    = s3_exact - out_p;
    assign sum_ext = 65'(err_sum) + 65'(diff);
    assign err_hit = out_valid && out_ready && out_approx && (diff != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_sum <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
            err_sum <= '0;
        end else if (err_hit) begin
            err_cnt <= (err_cnt == '1) ? '1 : err_cnt + 16'd1;
            err_sum <= (sum_ext > 65'h0_FFFF_FFFF) ? '1 : sum_ext[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed and scoreboarded checks of approx_mult_pipe at WIDTH=8/TRUNC_NIB=1 and WIDTH=16/TRUNC_NIB=3.
module tb_approx_mult_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid8, in_ready8, in_approx8, out_valid8, out_ready8, out_approx8;
    logic [7:0]  in_a8, in_b8;
    logic [15:0] out_p8;

    logic        in_valid16, in_ready16, in_approx16, out_valid16, out_ready16, out_approx16;
    logic [15:0] in_a16, in_b16;
    logic [31:0] out_p16;

`ifdef AMP_ERR_STAT_EN
    logic        err_clr8, err_clr16;
    logic [15:0] err_cnt8, err_cnt16;
    logic [31:0] err_sum8, err_sum16;
`endif

    int total = 0;
    int bad   = 0;

    approx_mult_pipe #(.WIDTH(8), .TRUNC_NIB(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_approx(in_approx8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_p(out_p8), .out_approx(out_approx8)
`ifdef AMP_ERR_STAT_EN
        , .err_clr(err_clr8), .err_cnt(err_cnt8), .err_sum(err_sum8)
`endif
    );

    approx_mult_pipe #(.WIDTH(16), .TRUNC_NIB(3)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_approx(in_approx16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_p(out_p16), .out_approx(out_approx16)
`ifdef AMP_ERR_STAT_EN
        , .err_clr(err_clr16), .err_cnt(err_cnt16), .err_sum(err_sum16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // a*b minus every nibble pair with i+j<3, for the 16-bit instance
    function automatic logic [32:0] gold16(input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        if (m) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (i + j < 3)
                        p = p - ((32'(a[4*i +: 4]) * 32'(b[4*j +: 4])) << (4 * (i + j)));
        end
        return {m, p};
    endfunction

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic [15:0] exp_p);
        in_valid8  = 1'b1;
        in_a8      = a;
        in_b8      = b;
        in_approx8 = m;
        @(negedge clk);
        in_valid8 = 1'b0;
        check({tag, "_v1"}, 64'(out_valid8), 64'd0);
        @(negedge clk);
        check({tag, "_v2"}, 64'(out_valid8), 64'd0);
        @(negedge clk);
        check({tag, "_v3"}, 64'(out_valid8), 64'd1);
        check({tag, "_p"}, 64'(out_p8), 64'(exp_p));
        check({tag, "_m"}, 64'(out_approx8), 64'(m));
        @(negedge clk);
    endtask

    logic [7:0]  t4a [5] = '{8'h12, 8'hFF, 8'hF0, 8'h0F, 8'hAB};
    logic [7:0]  t4b [5] = '{8'h34, 8'hFF, 8'h0F, 8'h0F, 8'hCD};
    logic        t4m [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] t4p [5] = '{16'h03A8, 16'hFD20, 16'h0E10, 16'h0000, 16'h88EF};

    initial begin
        int acc;
        int bi;
        logic rdy;
        logic [32:0] q[$];
        logic [32:0] e;

        rst_n = 1'b0;
        in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_approx8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_approx16 = 1'b0; out_ready16 = 1'b1;
`ifdef AMP_ERR_STAT_EN
        err_clr8 = 1'b0; err_clr16 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid8), 64'd0);
        check("rst_p", 64'(out_p8), 64'd0);
        check("rst_m", 64'(out_approx8), 64'd0);
        check("rst_ready", 64'(in_ready8), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run8("t1", 8'h12, 8'h34, 1'b0, 16'h03A8);
        run8("t2a", 8'hFF, 8'hFF, 1'b1, 16'hFD20);
        run8("t2e", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run8("t3lo", 8'h0F, 8'h0F, 1'b1, 16'h0000);
        run8("t3hi", 8'hF0, 8'h0F, 1'b1, 16'h0E10);

        // backpressure: only three beats fit while the output is stalled
        out_ready8 = 1'b0;
        acc = 0;
        bi  = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid8  = 1'b1;
            in_a8      = t4a[bi];
            in_b8      = t4b[bi];
            in_approx8 = t4m[bi];
            #1 rdy = in_ready8;
            @(negedge clk);
            if (rdy) begin
                acc++;
                bi++;
            end
        end
        check("t4_accepted", 64'(acc), 64'd3);
        check("t4_ready_low", 64'(in_ready8), 64'd0);
        check("t4_hold_v", 64'(out_valid8), 64'd1);
        check("t4_hold_p", 64'(out_p8), 64'(t4p[0]));
        @(negedge clk);
        check("t4_hold_p2", 64'(out_p8), 64'(t4p[0]));
        for (int d = 0; d < 5; d++) begin
            check($sformatf("t4_drain%0d_v", d), 64'(out_valid8), 64'd1);
            check($sformatf("t4_drain%0d_p", d), 64'(out_p8), 64'(t4p[d]));
            check($sformatf("t4_drain%0d_m", d), 64'(out_approx8), 64'(t4m[d]));
            if (d == 0) out_ready8 = 1'b1;
            if (d == 1) begin
                in_a8 = t4a[4]; in_b8 = t4b[4]; in_approx8 = t4m[4];
            end
            if (d == 2) in_valid8 = 1'b0;
            @(negedge clk);
        end
        check("t4_empty", 64'(out_valid8), 64'd0);

        // reset with beats in flight on the 16-bit instance
        in_valid16 = 1'b1; in_a16 = 16'h1111; in_b16 = 16'h2222; in_approx16 = 1'b0;
        repeat (3) @(negedge clk);
        in_valid16 = 1'b0;
        check("t5_pre_v", 64'(out_valid16), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_v", 64'(out_valid16), 64'd0);
        check("t5_rst_p", 64'(out_p16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_flushed", 64'(out_valid16), 64'd0);
        end
        in_valid16 = 1'b1; in_a16 = 16'h1234; in_b16 = 16'h5678; in_approx16 = 1'b0;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        check("t5_lat2", 64'(out_valid16), 64'd0);
        @(negedge clk);
        check("t5_lat3", 64'(out_valid16), 64'd1);
        check("t5_exact", 64'(out_p16), 64'h0626_0060);
        @(negedge clk);
        in_valid16 = 1'b1; in_a16 = 16'hFFFF; in_b16 = 16'hFFFF; in_approx16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_approx_ff", 64'(out_p16), 64'hFFFB_4000);
        check("t5_approx_m", 64'(out_approx16), 64'd1);
        @(negedge clk);

        // randomized stream with random stalls against the truncation model
        for (int c = 0; c < 300; c++) begin
            out_ready16 = ($urandom_range(0, 3) != 0);
            in_valid16  = ($urandom_range(0, 3) != 0);
            in_a16      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            in_b16      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            in_approx16 = 1'($urandom_range(0, 1));
            #1;
            if (in_valid16 && in_ready16) q.push_back(gold16(in_a16, in_b16, in_approx16));
            if (out_valid16 && out_ready16) begin
                if (q.size() == 0) begin
                    check("t5_rand_unexpected", 64'(out_p16), 64'd0 - 64'd1);
                end else begin
                    e = q.pop_front();
                    check("t5_rand_p", 64'(out_p16), 64'(e[31:0]));
                    check("t5_rand_m", 64'(out_approx16), 64'(e[32]));
                end
            end
            @(negedge clk);
        end
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid16 && q.size() != 0) begin
                e = q.pop_front();
                check("t5_drain_p", 64'(out_p16), 64'(e[31:0]));
                check("t5_drain_m", 64'(out_approx16), 64'(e[32]));
            end
            @(negedge clk);
        end
        check("t5_queue_empty", 64'(q.size()), 64'd0);
        check("t5_idle", 64'(out_valid16), 64'd0);

`ifdef AMP_ERR_STAT_EN
        err_clr8 = 1'b1;
        @(negedge clk);
        err_clr8 = 1'b0;
        check("t6_clr0_cnt", 64'(err_cnt8), 64'd0);
        run8("t6a", 8'hFF, 8'hFF, 1'b1, 16'hFD20);
        run8("t6e", 8'h12, 8'h34, 1'b0, 16'h03A8);
        check("t6_cnt", 64'(err_cnt8), 64'd1);
        check("t6_sum", 64'(err_sum8), 64'h0E1);
        err_clr8 = 1'b1;
        @(negedge clk);
        err_clr8 = 1'b0;
        check("t6_clr_cnt", 64'(err_cnt8), 64'd0);
        check("t6_clr_sum", 64'(err_sum8), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
